seg_disp_arbiter: RTL and testbench

//  Shares the single 6-digit seg_display instance between N_SRC requesters.

---
 rtl/seg_disp_arbiter.sv | 166 ++++++++++++++++
 tb/tb_seg_disp_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_arbiter.sv
// Purpose : round-robin owner of the shared 6-digit display, with a minimum dwell per grant.
// Latency : one cycle from req/src_data to grant/owner/dis_data; all outputs registered.
// Backpressure: none; losers keep req high and are served at the owner's dwell expiry or drop.
// Ports   : clk, rst_n (async active-low); req[N_SRC] level requests; src_data[24*N_SRC]
//           packed source values; grant (one-hot), owner, busy, switch_p (pulse on every
//           grant change) and dis_data (value feeding seg_display).
module seg_disp_arbiter #(
  parameter  int          N_SRC     = 4,
  parameter  int          DWELL     = 50_000_000,
  parameter  logic [23:0] IDLE_DATA = 24'h000000,
  localparam int          IDX_W     = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       req,
  input  logic [24*N_SRC-1:0]    src_data,
  output logic [N_SRC-1:0]       grant,
  output logic [IDX_W-1:0]       owner,
  output logic                   busy,
  output logic                   switch_p,
  output logic [23:0]            dis_data
);

  localparam int                DW_W    = $clog2(DWELL);
  localparam logic [DW_W-1:0]   DW_LAST = DW_W'(DWELL - 1);

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic               busy_q, busy_d;
  logic               switch_q, switch_d;
  logic [23:0]        dis_q, dis_d;

  logic [IDX_W:0]     pick_any;   // {found, index}, scan includes rr_q itself last
  logic [IDX_W:0]     pick_oth;   // {found, index}, scan excludes rr_q
  logic               take;
  logic               go_idle;
  logic [IDX_W-1:0]   new_k;

  // First asserted request scanning from+1, from+2, ... modulo N_SRC. The modulo keeps
  // non-existent indices out of reach when N_SRC is not a power of two.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_SRC-1:0] r,
                                             input logic [IDX_W-1:0] from,
                                             input logic             incl_self);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               cand;
    logic [IDX_W-1:0] ci;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = (int'(from) + i) % N_SRC;
      ci   = cand[IDX_W-1:0];
      if (!found && r[ci] && (incl_self || i < N_SRC)) begin
        found = 1'b1;
        idx   = ci;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    dwell_d  = dwell_q;
    busy_d   = busy_q;
    switch_d = 1'b0;
    dis_d    = dis_q;
    take     = 1'b0;
    go_idle  = 1'b0;
    new_k    = owner_q;
    pick_any = rr_pick(req, rr_q, 1'b1);
    // While showing, rr_q equals the owner, so this is "anyone but the owner".
    pick_oth = rr_pick(req, rr_q, 1'b0);

    case (state_q)
      S_IDLE: begin
        dis_d = IDLE_DATA;
        if (pick_any[IDX_W]) begin
          take  = 1'b1;
          new_k = pick_any[IDX_W-1:0];
        end
      end
      S_SHOW: begin
        dis_d = src_data[24*int'(owner_q) +: 24];
        if (!req[owner_q]) begin
          // Owner gave up early: hand over without waiting for the dwell.
          if (pick_oth[IDX_W]) begin
            take  = 1'b1;
            new_k = pick_oth[IDX_W-1:0];
          end else begin
            go_idle = 1'b1;
          end
        end else if (dwell_q == DW_LAST) begin
          if (pick_oth[IDX_W]) begin
            take  = 1'b1;
            new_k = pick_oth[IDX_W-1:0];
          end else begin
            // Sole requester keeps the display silently.
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // New owner's data loads on the same edge as its grant, never a mix of old and new.
    if (take) begin
      state_d        = S_SHOW;
      owner_d        = new_k;
      grant_d        = '0;
      grant_d[new_k] = 1'b1;
      busy_d         = 1'b1;
      switch_d       = 1'b1;
      dis_d          = src_data[24*int'(new_k) +: 24];
      dwell_d        = '0;
      rr_d           = new_k;
    end
    if (go_idle) begin
      state_d  = S_IDLE;
      owner_d  = '0;
      grant_d  = '0;
      busy_d   = 1'b0;
      switch_d = 1'b1;
      dis_d    = IDLE_DATA;
      dwell_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_q     <= IDX_W'(N_SRC - 1);  // first grant scans from source 0
      dwell_q  <= '0;
      busy_q   <= 1'b0;
      switch_q <= 1'b0;
      dis_q    <= IDLE_DATA;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      dwell_q  <= dwell_d;
      busy_q   <= busy_d;
      switch_q <= switch_d;
      dis_q    <= dis_d;
    end
  end

  assign grant    = grant_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign switch_p = switch_q;
  assign dis_data = dis_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
module tb_seg_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [95:0] src_data;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic        switch_p;
  logic [23:0] dis_data;

  int checks = 0;
  int errors = 0;

  // Expected output word per cycle: {grant, owner, busy, switch_p, dis_data}.
  logic [31:0] exp_q[$];

  seg_disp_arbiter #(.N_SRC(4), .DWELL(4), .IDLE_DATA(24'h000000)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data),
    .grant(grant), .owner(owner), .busy(busy), .switch_p(switch_p), .dis_data(dis_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] g, input logic [1:0] o,
                                     input logic b, input logic s, input logic [23:0] d);
    return {g, o, b, s, d};
  endfunction

  function automatic logic [31:0] shown(input int k, input logic s);
    logic [3:0] g;
    g = 4'b0001 << k;
    return mk(g, 2'(k), 1'b1, s, src_data[24*k +: 24]);
  endfunction

  function automatic logic [31:0] idle_w(input logic s);
    return mk(4'b0000, 2'd0, 1'b0, s, 24'h000000);
  endfunction

  task automatic set_src(input int k, input logic [23:0] v);
    src_data[24*k +: 24] = v;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    e = idle_w(1'b0);
    checks++;
    if ({grant, owner, busy, switch_p, dis_data} !== e) begin
      errors++;
      $display("FAIL reset_hold: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(idle_w(1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, switch_p, dis_data} !== e) begin
        errors++;
        $display("FAIL idle_no_req: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
      end
    end
  endtask

  task automatic test_single_hold;
    logic [31:0] e;
    req = 4'b0010;
    exp_q.push_back(shown(1, 1'b1));
    for (int i = 0; i < 12; i++) exp_q.push_back(shown(1, 1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, switch_p, dis_data} !== e) begin
        errors++;
        $display("FAIL single_hold: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [31:0] e;
    int order[4] = '{0, 1, 3, 0};
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1011;
    for (int g = 0; g < 4; g++)
      for (int c = 0; c < 4; c++) exp_q.push_back(shown(order[g], c == 0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, switch_p, dis_data} !== e) begin
        errors++;
        $display("FAIL round_robin: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
      end
    end
    req = 4'b0000;
    exp_q.push_back(idle_w(1'b1));
    exp_q.push_back(idle_w(1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, switch_p, dis_data} !== e) begin
        errors++;
        $display("FAIL rr_to_idle: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
      end
    end
  endtask

  task automatic test_early_drop;
    logic [31:0] e;
    // Pointer sits at 0 here, so source 1 wins first.
    req = 4'b0011;
    exp_q.push_back(shown(1, 1'b1));
    exp_q.push_back(shown(1, 1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, switch_p, dis_data} !== e) begin
        errors++;
        $display("FAIL drop_pre: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
      end
    end
    req = 4'b0001;
    exp_q.push_back(shown(0, 1'b1));
    for (int i = 0; i < 5; i++) exp_q.push_back(shown(0, 1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, switch_p, dis_data} !== e) begin
        errors++;
        $display("FAIL drop_repick: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
      end
    end
    req = 4'b0000;
    exp_q.push_back(idle_w(1'b1));
    exp_q.push_back(idle_w(1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, switch_p, dis_data} !== e) begin
        errors++;
        $display("FAIL drop_idle: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
      end
    end
  endtask

  task automatic test_live_data;
    logic [31:0] e;
    set_src(2, 24'hAAAAAA);
    req = 4'b0100;
    exp_q.push_back(shown(2, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({grant, owner, busy, switch_p, dis_data} !== e) begin
      errors++;
      $display("FAIL live_grant: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
    end
    set_src(2, 24'h00BEEF);
    for (int i = 0; i < 3; i++) exp_q.push_back(shown(2, 1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, switch_p, dis_data} !== e) begin
        errors++;
        $display("FAIL live_track: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] e;
    req = 4'b1000;
    exp_q.push_back(shown(3, 1'b1));
    exp_q.push_back(shown(3, 1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, switch_p, dis_data} !== e) begin
        errors++;
        $display("FAIL owner3: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
      end
    end
    rst_n = 1'b0;
    exp_q.push_back(idle_w(1'b0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({grant, owner, busy, switch_p, dis_data} !== e) begin
      errors++;
      $display("FAIL async_reset: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
    end
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) exp_q.push_back(shown(0, c == 0));
    exp_q.push_back(shown(1, 1'b1));
    exp_q.push_back(shown(1, 1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, switch_p, dis_data} !== e) begin
        errors++;
        $display("FAIL post_reset: observed %h expected %h", {grant, owner, busy, switch_p, dis_data}, e);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0000;
    src_data = '0;
    set_src(0, 24'h111111);
    set_src(1, 24'h123456);
    set_src(2, 24'hAAAAAA);
    set_src(3, 24'h333333);
    test_reset();
    test_single_hold();
    test_round_robin();
    test_early_drop();
    test_live_data();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
